// File: rtl/updown_counter_mod_pkg.sv
// Shared constants for the up/down counter family: direction encoding and
// end-of-range mode selection.
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface updown_counter_mod_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             m;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             evt;

    modport master (
        output en, m, load, load_val,
        input  count, tc, evt
    );

    modport slave (
        input  en, m, load, load_val,
        output count, tc, evt
    );

endinterface : updown_counter_mod_if

// File: rtl/updown_counter_mod_next.sv
// Combinational step logic: next value for one count step, end-of-range
// detection in the current direction, and the wrap/blocked event.
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             m,
    output logic [WIDTH-1:0] next_count,
    output logic             at_end,
    output logic             step_evt
);

    // One extra bit so MODULUS == 2**WIDTH neither overflows LAST nor the +1.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] cnt_inc;
    logic [WIDTH:0] cnt_dec;

    assign cnt_ext = {1'b0, count};
    assign cnt_inc = cnt_ext + 1'b1;
    assign cnt_dec = cnt_ext - 1'b1;

    always_comb begin
        next_count = count;
        at_end     = 1'b0;
        step_evt   = 1'b0;
        if (m == DIR_UP) begin
            at_end = (cnt_ext == LAST);
            if (at_end) begin
                step_evt = 1'b1;
                if (SATURATE == MODE_WRAP)
                    next_count = '0;
            end else begin
                next_count = cnt_inc[WIDTH-1:0];
            end
        end else begin
            at_end = (cnt_ext == '0);
            if (at_end) begin
                step_evt = 1'b1;
                if (SATURATE == MODE_WRAP)
                    next_count = LAST[WIDTH-1:0];
            end else begin
                next_count = cnt_dec[WIDTH-1:0];
            end
        end
    end

endmodule : updown_next

// File: rtl/updown_counter_mod.sv
// Synchronous parametrised up/down counter with load, enable, wrap/saturate
// modes, terminal-count flag and a registered end-of-range event pulse.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                clk,
    input  logic                rst,
    updown_counter_mod_if.slave bus
);

    localparam longint RANGE_MAX = longint'(1) << WIDTH;

    generate
        if (MODULUS < 2 || longint'(MODULUS) > RANGE_MAX) begin : g_bad_modulus
            $error("updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
            $error("updown_counter_mod: SATURATE must be 0 or 1");
        end
    endgenerate

    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST    = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic             evt_q;
    logic [WIDTH-1:0] next_count;
    logic             at_end;
    logic             step_evt;
    logic [WIDTH-1:0] load_clamped;

    updown_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .m          (bus.m),
        .next_count (next_count),
        .at_end     (at_end),
        .step_evt   (step_evt)
    );

    // Out-of-range loads land on the top of the range rather than escaping it.
    assign load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val
                                                           : LAST[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            evt_q   <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            evt_q   <= 1'b0;
        end else if (bus.en) begin
            count_q <= next_count;
            evt_q   <= step_evt;
        end else begin
            evt_q   <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.evt   = evt_q;
    assign bus.tc    = at_end;

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Directed bench: wrap (M=10), saturate (M=10) and full-range (M=16) counters.
module tb_updown_counter_mod;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    updown_counter_mod_if #(.WIDTH(4)) bw ();
    updown_counter_mod_if #(.WIDTH(4)) bs ();
    updown_counter_mod_if #(.WIDTH(4)) bf ();

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_WRAP)) u_wrap (
        .clk (clk), .rst (rst), .bus (bw));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_SAT)) u_sat (
        .clk (clk), .rst (rst), .bus (bs));
    updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) u_full (
        .clk (clk), .rst (rst), .bus (bf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input int c, input int e, input int t);
        chk({tag, "_cnt"}, 32'(bw.count), c);
        chk({tag, "_evt"}, 32'(bw.evt), e);
        chk({tag, "_tc"},  32'(bw.tc), t);
    endtask

    task automatic chk_s(input string tag, input int c, input int e, input int t);
        chk({tag, "_cnt"}, 32'(bs.count), c);
        chk({tag, "_evt"}, 32'(bs.evt), e);
        chk({tag, "_tc"},  32'(bs.tc), t);
    endtask

    task automatic chk_f(input string tag, input int c, input int e, input int t);
        chk({tag, "_cnt"}, 32'(bf.count), c);
        chk({tag, "_evt"}, 32'(bf.evt), e);
        chk({tag, "_tc"},  32'(bf.tc), t);
    endtask

    initial begin
        bw.en = 0; bw.m = 0; bw.load = 0; bw.load_val = '0;
        bs.en = 0; bs.m = 0; bs.load = 0; bs.load_val = '0;
        bf.en = 0; bf.m = 0; bf.load = 0; bf.load_val = '0;

        // Reset state
        rst = 1;
        step();
        chk_w("rst_w", 0, 0, 0);
        chk_s("rst_s", 0, 0, 0);
        chk_f("rst_f", 0, 0, 0);

        // Up count with wrap at 9 -> 0
        rst = 0; bw.en = 1; bw.m = DIR_UP;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_w($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, ((i % 10) == 9) ? 1 : 0);
        end

        // Load 2 then count down through the wrap
        bw.en = 0; bw.load = 1; bw.load_val = 4'd2;
        step();
        chk_w("ld2", 2, 0, 0);
        bw.load = 0; bw.en = 1; bw.m = DIR_DOWN;
        step(); chk_w("dn1", 1, 0, 0);
        step(); chk_w("dn0", 0, 0, 1);
        step(); chk_w("dn9", 9, 1, 0);
        step(); chk_w("dn8", 8, 0, 0);

        // Direction flip: tc follows m without a clock
        bw.m = DIR_UP;
        #1;
        chk("flip_tc8", 32'(bw.tc), 0);
        step(); chk_w("fl9", 9, 0, 1);
        step(); chk_w("fl0", 0, 1, 0);

        // Load beats enable, and out-of-range values clamp to 9
        bw.load = 1; bw.load_val = 4'd13;
        step(); chk_w("clamp", 9, 0, 1);

        // Reset beats load
        rst = 1; bw.load_val = 4'd5;
        step(); chk_w("rst_ld", 0, 0, 0);
        rst = 0;

        // Enable hold
        bw.load_val = 4'd6;
        step(); chk_w("ld6", 6, 0, 0);
        bw.load = 0; bw.en = 0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_w($sformatf("hold%0d", i), 6, 0, 0);
        end

        // Reset mid-count, then resume
        bw.en = 1; rst = 1;
        step(); chk_w("rst_mid", 0, 0, 0);
        rst = 0;
        step(); chk_w("res1", 1, 0, 0);
        step(); chk_w("res2", 2, 0, 0);
        bw.en = 0;

        // Saturating counter: hold at 9 with repeated evt
        bs.load = 1; bs.load_val = 4'd8;
        step(); chk_s("s_ld8", 8, 0, 0);
        bs.load = 0; bs.en = 1; bs.m = DIR_UP;
        step(); chk_s("s_up9", 9, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(); chk_s($sformatf("s_hold%0d", i), 9, 1, 1);
        end
        bs.m = DIR_DOWN;
        step(); chk_s("s_dn8", 8, 0, 0);

        // Saturating at the bottom
        bs.load = 1; bs.load_val = 4'd1;
        step(); chk_s("s_ld1", 1, 0, 0);
        bs.load = 0;
        step(); chk_s("s_dn0", 0, 0, 1);
        step(); chk_s("s_lo", 0, 1, 1);
        bs.en = 0;
        step(); chk_s("s_idle", 0, 0, 1);

        // Full-range counter: wraps at both ends of 0..15
        bf.load = 1; bf.load_val = 4'd15; bf.m = DIR_UP;
        step(); chk_f("f_ld15", 15, 0, 1);
        bf.load = 0; bf.en = 1;
        step(); chk_f("f_up0", 0, 1, 0);
        bf.m = DIR_DOWN;
        step(); chk_f("f_dn15", 15, 1, 0);
        step(); chk_f("f_dn14", 14, 0, 0);
        bf.en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_updown_counter_mod
